// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and iterative shift-add multiply
// Result registers hold until consumed; MUL takes WIDTH iterations, all other ops complete in one cycle.

module alu_pipe #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       status,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_PASSA = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ma;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic [3:0]       r_status;

    logic             w_accept;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_b_sel;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic signed [WIDTH:0] w_sra_src;
    logic [WIDTH:0]   w_sra;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_illegal;
    logic [3:0]       w_status;
    logic [WIDTH-1:0] w_mul_acc;
    logic             w_mul_last;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state == ST_MUL);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign status    = r_status;

    // Shifts carry an extra guard bit so the last bit shifted out lands in bit WIDTH or bit 0.
    always_comb begin
        w_sh      = b[SHW-1:0];
        w_b_sel   = (op == OP_SUB) ? ~b : b;
        w_sum     = {1'b0, a} + {1'b0, w_b_sel} + {{WIDTH{1'b0}}, cin};
        w_shl     = {1'b0, a} << w_sh;
        w_shr     = {a, 1'b0} >> w_sh;
        w_sra_src = {a, 1'b0};
        w_sra     = w_sra_src >>> w_sh;
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_illegal = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   w_res = a & b;
            OP_OR:    w_res = a | b;
            OP_XOR:   w_res = a ^ b;
            OP_NOT:   w_res = ~a;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_SRA: begin
                w_res = w_sra[WIDTH:1];
                w_c   = w_sra[0];
            end
            OP_PASSA: w_res = a;
            default:  w_illegal = 1'b1;
        endcase
        w_status = w_illegal ? 4'b0001 : {w_v, w_c, w_res[WIDTH-1], ~|w_res};
    end

    assign w_mul_acc  = r_acc + (r_mb[0] ? r_ma : '0);
    assign w_mul_last = (r_cnt == SHW'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_status    <= 4'b0000;
        end else if (r_state == ST_MUL) begin
            r_acc <= w_mul_acc;
            r_ma  <= r_ma << 1;
            r_mb  <= r_mb >> 1;
            r_cnt <= r_cnt + SHW'(1);
            if (w_mul_last) begin
                r_result    <= w_mul_acc;
                r_cout      <= 1'b0;
                r_status    <= {2'b00, w_mul_acc[WIDTH-1], ~|w_mul_acc};
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
            end
        end else if (w_accept) begin
            if (op == OP_MUL) begin
                r_ma        <= a;
                r_mb        <= b;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_out_valid <= 1'b0;
                r_state     <= ST_MUL;
            end else begin
                r_result    <= w_res;
                r_cout      <= w_illegal ? 1'b0 : w_c;
                r_status    <= w_status;
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
            end
        end else if ((r_state == ST_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
        end else if (r_state != ST_DONE && r_state != ST_IDLE) begin
            // Unreachable encoding: recover rather than lock up with in_ready low.
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH=64 and WIDTH=8

module tb_alu_pipe;

    logic        clk;
    logic        rst64;
    logic        rst8;

    logic        d64_in_valid;
    logic        d64_in_ready;
    logic [63:0] d64_a;
    logic [63:0] d64_b;
    logic        d64_cin;
    logic [3:0]  d64_op;
    logic        d64_out_valid;
    logic        d64_out_ready;
    logic [63:0] d64_result;
    logic        d64_cout;
    logic [3:0]  d64_status;
    logic        d64_busy;

    logic        d8_in_valid;
    logic        d8_in_ready;
    logic [7:0]  d8_a;
    logic [7:0]  d8_b;
    logic        d8_cin;
    logic [3:0]  d8_op;
    logic        d8_out_valid;
    logic        d8_out_ready;
    logic [7:0]  d8_result;
    logic        d8_cout;
    logic [3:0]  d8_status;
    logic        d8_busy;

    int n_checks;
    int n_pass;

    alu_pipe #(.WIDTH(64), .SHW(6)) u_dut64 (
        .clock     (clk),
        .reset     (rst64),
        .in_valid  (d64_in_valid),
        .in_ready  (d64_in_ready),
        .a         (d64_a),
        .b         (d64_b),
        .cin       (d64_cin),
        .op        (d64_op),
        .out_valid (d64_out_valid),
        .out_ready (d64_out_ready),
        .result    (d64_result),
        .cout      (d64_cout),
        .status    (d64_status),
        .busy      (d64_busy)
    );

    alu_pipe #(.WIDTH(8), .SHW(3)) u_dut8 (
        .clock     (clk),
        .reset     (rst8),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .a         (d8_a),
        .b         (d8_b),
        .cin       (d8_cin),
        .op        (d8_op),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .result    (d8_result),
        .cout      (d8_cout),
        .status    (d8_status),
        .busy      (d8_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Single-cycle op on the 64-bit instance, then drain the result.
    task automatic run64(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic cin,
                         input logic [63:0] exp_res, input logic [3:0] exp_st);
        check({tag, "_in_ready"}, d64_in_ready, 1);
        d64_op = op; d64_a = a; d64_b = b; d64_cin = cin; d64_in_valid = 1'b1;
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        check({tag, "_valid"}, d64_out_valid, 1);
        check({tag, "_res"}, d64_result, exp_res);
        check({tag, "_status"}, d64_status, exp_st);
        check({tag, "_cout"}, d64_cout, exp_st[2]);
        d64_out_ready = 1'b1;
        @(posedge clk); #1;
        d64_out_ready = 1'b0;
        check({tag, "_drained"}, d64_out_valid, 0);
    endtask

    task automatic mul64(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input logic [3:0] exp_st);
        int n;
        d64_op = 4'd10; d64_a = a; d64_b = b; d64_cin = 1'b0; d64_in_valid = 1'b1;
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        check({tag, "_busy"}, d64_busy, 1);
        n = 0;
        while (!d64_out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, 64);
        check({tag, "_res"}, d64_result, exp_res);
        check({tag, "_status"}, d64_status, exp_st);
        d64_out_ready = 1'b1;
        @(posedge clk); #1;
        d64_out_ready = 1'b0;
        check({tag, "_drained"}, d64_out_valid, 0);
    endtask

    task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic [3:0] exp_st);
        int lat;
        int busy_cnt;
        d8_op = 4'd10; d8_a = a; d8_b = b; d8_cin = 1'b0; d8_in_valid = 1'b1;
        @(posedge clk); #1;
        d8_in_valid = 1'b0;
        check({tag, "_in_ready_mul"}, d8_in_ready, 0);
        lat = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            if (d8_busy) busy_cnt++;
            if (d8_out_valid) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_latency"}, lat, 9);
        check({tag, "_busy_cycles"}, busy_cnt, 8);
        check({tag, "_res"}, d8_result, exp_res);
        check({tag, "_status"}, d8_status, exp_st);
        d8_out_ready = 1'b1;
        @(posedge clk); #1;
        d8_out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst64 = 1'b1; rst8 = 1'b1;
        d64_in_valid = 1'b0; d64_a = '0; d64_b = '0; d64_cin = 1'b0; d64_op = '0; d64_out_ready = 1'b0;
        d8_in_valid  = 1'b0; d8_a  = '0; d8_b  = '0; d8_cin  = 1'b0; d8_op  = '0; d8_out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", d64_out_valid, 0);
        check("rst_result", d64_result, 0);
        check("rst_cout", d64_cout, 0);
        check("rst_status", d64_status, 0);
        check("rst_busy", d64_busy, 0);
        check("rst_in_ready", d64_in_ready, 1);
        rst64 = 1'b0; rst8 = 1'b0;
        @(posedge clk); #1;

        run64("add_3_1",   4'd0, 64'd3, 64'd1, 1'b0, 64'd4, 4'b0000);
        run64("sub_2_4",   4'd1, 64'd2, 64'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010);
        run64("sub_3_3",   4'd1, 64'd3, 64'd3, 1'b1, 64'd0, 4'b0101);
        run64("add_ovf",   4'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b1101);
        run64("and",       4'd2, 64'd11, 64'd14, 1'b0, 64'd10, 4'b0000);
        run64("or",        4'd3, 64'd3, 64'd4, 1'b0, 64'd7, 4'b0000);
        run64("xor",       4'd4, 64'd2, 64'd5, 1'b0, 64'd7, 4'b0000);
        run64("not",       4'd5, 64'd0, 64'd9, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
        run64("shl",       4'd6, 64'd23, 64'd3, 1'b0, 64'd184, 4'b0000);
        run64("shr",       4'd7, 64'd23, 64'd3, 1'b0, 64'd2, 4'b0100);
        run64("shr_sh0",   4'd7, 64'd23, 64'h40, 1'b0, 64'd23, 4'b0000);
        run64("sra",       4'd8, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 64'hF800_0000_0000_0000, 4'b0010);
        run64("passa",     4'd9, 64'd0, 64'd5, 1'b0, 64'd0, 4'b0001);
        run64("illegal13", 4'd13, 64'd5, 64'd6, 1'b1, 64'd0, 4'b0001);

        // Backpressure then back-to-back accept.
        d64_op = 4'd0; d64_a = 64'd2; d64_b = 64'd2; d64_cin = 1'b0; d64_in_valid = 1'b1;
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", d64_out_valid, 1);
            check("bp_result", d64_result, 4);
            check("bp_in_ready", d64_in_ready, 0);
            @(posedge clk); #1;
        end
        d64_out_ready = 1'b1;
        d64_op = 4'd4; d64_a = 64'd2; d64_b = 64'd5; d64_in_valid = 1'b1;
        #1;
        check("b2b_in_ready", d64_in_ready, 1);
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        check("b2b_valid", d64_out_valid, 1);
        check("b2b_result", d64_result, 7);
        check("b2b_status", d64_status, 4'b0000);
        @(posedge clk); #1;
        d64_out_ready = 1'b0;
        check("b2b_drained", d64_out_valid, 0);

        // Reset five cycles into a MUL.
        d64_op = 4'd10; d64_a = 64'd3; d64_b = 64'd4; d64_in_valid = 1'b1;
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        check("mulrst_busy", d64_busy, 1);
        check("mulrst_in_ready", d64_in_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        rst64 = 1'b1;
        #1;
        check("mulrst_out_valid", d64_out_valid, 0);
        check("mulrst_status", d64_status, 0);
        check("mulrst_in_ready", d64_in_ready, 1);
        check("mulrst_busy_low", d64_busy, 0);
        @(posedge clk); #1;
        rst64 = 1'b0;
        check("mulrst_no_result", d64_out_valid, 0);
        mul64("mul64_3_4", 64'd3, 64'd4, 64'd12, 4'b0000);
        mul64("mul64_wrap", 64'h8000_0000_0000_0001, 64'd3, 64'h8000_0000_0000_0003, 4'b0010);
        run64("after_mul", 4'd0, 64'd5, 64'd6, 1'b0, 64'd11, 4'b0000);

        mul8("mul8_13_11", 8'd13, 8'd11, 8'h8F, 4'b0010);
        mul8("mul8_wrap",  8'd200, 8'd3, 8'h58, 4'b0000);
        mul8("mul8_zero",  8'd16, 8'd16, 8'h00, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the 64-bit combinational ALU file. Accepts one operation per handshake, returns the result with carry-out and a {V,C,N,Z} status word, and holds each result until the consumer takes it. Adds an iterative multi-cycle multiply and arithmetic shift right. Sits between the register file read ports and the writeback mux in the datapath.

Parameters:
WIDTH, 64, operand/result width; must be a power of 2, at least 8.
SHW, 6, shift-amount bits taken from b; must equal log2(WIDTH).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount
cin  in  1  carry-in (ADD/SUB only)
op  in  4  operation select
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes the result this cycle
result  out  WIDTH  registered result
cout  out  1  registered carry-out, same value as status[2]
status  out  4  registered {V,C,N,Z}
busy  out  1  high while in MUL state

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, out_valid=0, result=0, cout=0, status=0, busy=0, in_ready=1.
- Reset during MUL aborts the operation. No result is produced.
- Op encoding:
  - 0 ADD: a+b+cin
  - 1 SUB: a+~b+cin. cin=1 gives a true subtract.
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~a
  - 6 SHL: a<<sh
  - 7 SHR: logical right shift
  - 8 SRA: arithmetic right shift
  - 9 PASSA: a
  - 10 MUL: low WIDTH bits of a*b, unsigned
  - 11-15 illegal: result=0, status=4'b0001.
- Shift amount: sh = b[SHW-1:0], so sh is always below WIDTH.
- Flags:
  - Z: result==0.
  - N: result[WIDTH-1].
  - C, ADD/SUB: carry out of bit WIDTH-1 of the WIDTH+1-bit sum.
  - C, SHL/SHR/SRA: last bit shifted out; 0 when sh==0.
  - C, all other ops: 0.
  - V, ADD: a,b MSBs equal and result MSB differs from a MSB.
  - V, SUB: a,b MSBs differ and result MSB differs from a MSB.
  - V, all other ops: 0.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - The output is taken when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, result/cout/status stay stable and in_ready=0.
- State machine: IDLE, MUL, DONE.
  - IDLE, accept of a non-MUL op: compute combinationally, register outputs, go to DONE. out_valid=1 on the next cycle (latency 1).
  - IDLE, accept of MUL: latch a, b; clear accumulator and counter; go to MUL; busy=1.
  - MUL: shift-add one multiplier bit per cycle for WIDTH cycles. Counter runs 0..WIDTH-1. On the last iteration, register result and flags and go to DONE. out_valid rises WIDTH+1 cycles after acceptance. in_inputs are ignored; in_ready=0.
  - DONE, out_ready=0: hold all outputs.
  - DONE, out_ready=1 with no new accept: go to IDLE; out_valid=0 next cycle.
  - DONE, out_ready=1 with a simultaneous accept: back-to-back. A non-MUL op stays in DONE with new values and out_valid=1. A MUL op goes to MUL with out_valid=0.
- Arithmetic is modulo 2^WIDTH. No internal saturation.

Test Plan:
- Reset mid-MUL: assert reset 5 cycles into MUL of a=3,b=4 -> out_valid=0, status=0, in_ready=1 immediately; the next op completes normally.
- ADD/SUB flags, WIDTH=64, each accept followed by out_ready=1:
  - ADD a=3,b=1,cin=0 -> result=4, status=0000.
  - SUB a=2,b=4,cin=1 -> result=0xFFFF_FFFF_FFFF_FFFE, status=0010.
  - SUB a=3,b=3,cin=1 -> result=0, status=0101.
  - ADD a=0x8000_0000_0000_0000,b=same,cin=0 -> result=0, status=1101.
- Logic and shifts, WIDTH=64:
  - AND 11&14=10.
  - OR 3|4=7.
  - XOR 2^5=7.
  - SHL 23<<3=184, C=0.
  - SHR 23>>3=2, C=1.
  - SRA 0x8000_0000_0000_0000 by 4 = 0xF800_0000_0000_0000, status=0010.
- MUL latency, WIDTH=8, a=13,b=11 -> out_valid exactly 9 cycles after accept; result=143 (0x8F), status=0010, busy high for 8 cycles.
- Backpressure/back-to-back: hold out_ready=0 for 3 cycles after ADD 2+2 -> result stays 4, in_ready=0. Then out_ready=1 with in_valid for XOR 2^5 in the same cycle -> next cycle result=7, out_valid stays 1.
- Illegal op 13 -> result=0, status=0001.
